// File: rtl/mcycle_ctrl.sv
// rtl/mcycle_ctrl.sv - machine-cycle / T-state sequencer for an 8080-style bus unit
module mcycle_ctrl #(
    parameter int INSTSIZE = 13
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic [INSTSIZE-1:0] chk_i,
    input  logic                ready,
    output logic                ale,
    output logic                rd_,
    output logic                wr_,
    output logic                enb_c,
    output logic                enb_d,
    output logic                enbrr,
    output logic                enbwr,
    output logic                pcinc,
    output logic [2:0]          tstat,
    output logic [2:0]          mcyc,
    output logic                halted
);

    typedef enum logic [3:0] {
        S_IDLE, S_T1, S_T2, S_TW, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] mcyc_q, mcyc_d;
    logic       wcyc_q, wcyc_d;
    logic [3:0] cycgo_q, cycrw_q;
    logic       hlt_q;

    logic       ale_q, rd_n_q, wr_n_q, enb_c_q, enb_d_q, enbrr_q, enbwr_q, pcinc_q, halted_q;
    logic       ale_d, rd_n_d, wr_n_d, enb_c_d, enb_d_d, enbrr_d, enbwr_d, pcinc_d, halted_d;
    logic [2:0] tstat_q, tstat_d;

    logic       latch_now, hlt_eff, more, in_bus, m1_d;
    logic [3:0] go_eff, rw_eff;
    logic       unused_chk;

    assign unused_chk = ^chk_i;

    // The decision leaving M1 T4 is taken in the same clock the info is latched,
    // so it must look at chk_i directly rather than the not-yet-loaded copies.
    assign latch_now = (state_q == S_T4) && (mcyc_q == 3'd0);
    assign go_eff    = latch_now ? chk_i[7:4]  : cycgo_q;
    assign rw_eff    = latch_now ? chk_i[11:8] : cycrw_q;
    assign hlt_eff   = latch_now ? chk_i[2]    : hlt_q;
    assign more      = (mcyc_q < 3'd4) && go_eff[mcyc_q[1:0]];

    always_comb begin
        state_d = state_q;
        mcyc_d  = mcyc_q;
        wcyc_d  = wcyc_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_T1;
                mcyc_d  = 3'd0;
                wcyc_d  = 1'b0;
            end
            S_T1:       state_d = S_T2;
            S_T2, S_TW: state_d = ready ? S_T3 : S_TW;
            S_T3: begin
                if (mcyc_q == 3'd0) begin
                    state_d = S_T4;
                end else if (hlt_eff && (mcyc_q == 3'd1)) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T1;
                    mcyc_d  = more ? mcyc_q + 3'd1 : 3'd0;
                    wcyc_d  = more ? rw_eff[mcyc_q[1:0]] : 1'b0;
                end
            end
            S_T4: begin
                if (chk_i[0]) begin
                    state_d = S_T5;
                end else begin
                    state_d = S_T1;
                    mcyc_d  = more ? mcyc_q + 3'd1 : 3'd0;
                    wcyc_d  = more ? rw_eff[mcyc_q[1:0]] : 1'b0;
                end
            end
            S_T5: state_d = S_T6;
            S_T6: begin
                state_d = S_T1;
                mcyc_d  = more ? mcyc_q + 3'd1 : 3'd0;
                wcyc_d  = more ? rw_eff[mcyc_q[1:0]] : 1'b0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs: decoded from the next state and registered with it.
    always_comb begin
        in_bus   = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);
        m1_d     = (mcyc_d == 3'd0);
        ale_d    = (state_d == S_T1);
        rd_n_d   = !(in_bus && !wcyc_d);
        wr_n_d   = !(in_bus && wcyc_d);
        enb_c_d  = (state_d == S_T3) && m1_d;
        enb_d_d  = (state_d == S_T3) && !m1_d && !wcyc_d;
        enbrr_d  = ((state_d == S_T4) && m1_d) || (in_bus && wcyc_d);
        enbwr_d  = ((state_d == S_T4) && m1_d && (chk_i[7:4] == 4'd0)) ||
                   ((state_d == S_T1) && m1_d && (state_q == S_T3) &&
                    (mcyc_q != 3'd0) && !wcyc_q);
        pcinc_d  = (state_d == S_T2) && (state_q == S_T1) && !wcyc_d;
        halted_d = (state_d == S_HALT);
        unique case (state_d)
            S_T1:    tstat_d = 3'd1;
            S_T2:    tstat_d = 3'd2;
            S_T3:    tstat_d = 3'd3;
            S_T4:    tstat_d = 3'd4;
            S_T5:    tstat_d = 3'd5;
            S_T6:    tstat_d = 3'd6;
            S_TW:    tstat_d = 3'd7;
            default: tstat_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state_q  <= S_IDLE;
            mcyc_q   <= 3'd0;
            wcyc_q   <= 1'b0;
            cycgo_q  <= 4'd0;
            cycrw_q  <= 4'd0;
            hlt_q    <= 1'b0;
            ale_q    <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            enb_c_q  <= 1'b0;
            enb_d_q  <= 1'b0;
            enbrr_q  <= 1'b0;
            enbwr_q  <= 1'b0;
            pcinc_q  <= 1'b0;
            halted_q <= 1'b0;
            tstat_q  <= 3'd0;
        end else begin
            state_q  <= state_d;
            mcyc_q   <= mcyc_d;
            wcyc_q   <= wcyc_d;
            if (latch_now) begin
                cycgo_q <= chk_i[7:4];
                cycrw_q <= chk_i[11:8];
                hlt_q   <= chk_i[2];
            end
            ale_q    <= ale_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            enb_c_q  <= enb_c_d;
            enb_d_q  <= enb_d_d;
            enbrr_q  <= enbrr_d;
            enbwr_q  <= enbwr_d;
            pcinc_q  <= pcinc_d;
            halted_q <= halted_d;
            tstat_q  <= tstat_d;
        end
    end

    assign ale    = ale_q;
    assign rd_    = rd_n_q;
    assign wr_    = wr_n_q;
    assign enb_c  = enb_c_q;
    assign enb_d  = enb_d_q;
    assign enbrr  = enbrr_q;
    assign enbwr  = enbwr_q;
    assign pcinc  = pcinc_q;
    assign tstat  = tstat_q;
    assign mcyc   = mcyc_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// tb/tb_mcycle_ctrl.sv - table-driven scoreboard bench for mcycle_ctrl
module tb_mcycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_ = 1'b1;
    logic [12:0] chk_i = 13'd0;
    logic        ready = 1'b1;
    logic        ale, rd_, wr_, enb_c, enb_d, enbrr, enbwr, pcinc, halted;
    logic [2:0]  tstat, mcyc;

    int checks = 0;
    int failures = 0;

    mcycle_ctrl #(.INSTSIZE(13)) dut (
        .clk(clk), .rst_(rst_), .chk_i(chk_i), .ready(ready),
        .ale(ale), .rd_(rd_), .wr_(wr_), .enb_c(enb_c), .enb_d(enb_d),
        .enbrr(enbrr), .enbwr(enbwr), .pcinc(pcinc),
        .tstat(tstat), .mcyc(mcyc), .halted(halted)
    );

    always #5 clk = ~clk;

    // strobe field: {ale, rd_, wr_, enb_c, enb_d, enbrr, enbwr, pcinc, halted}
    localparam logic [8:0] IDL = 9'b011000000;
    localparam logic [8:0] ALE = 9'b111000000;
    localparam logic [8:0] ALW = 9'b111000100;
    localparam logic [8:0] RDP = 9'b001000010;
    localparam logic [8:0] RDC = 9'b001100000;
    localparam logic [8:0] RDD = 9'b001010000;
    localparam logic [8:0] RDW = 9'b001000000;
    localparam logic [8:0] T4W = 9'b011001100;
    localparam logic [8:0] T4R = 9'b011001000;
    localparam logic [8:0] WRR = 9'b010001000;
    localparam logic [8:0] HLT = 9'b011000001;

    typedef struct {
        logic [12:0] chk;
        logic        rdy;
        logic [2:0]  ts;
        logic [2:0]  mc;
        logic [8:0]  sb;
    } vec_t;

    vec_t        tbl[$];
    logic [14:0] exp_q[$];

    task automatic add(input logic [12:0] c, input logic r, input logic [2:0] ts,
                       input logic [2:0] mc, input logic [8:0] sb);
        vec_t v;
        v.chk = c; v.rdy = r; v.ts = ts; v.mc = mc; v.sb = sb;
        tbl.push_back(v);
    endtask

    task automatic compare(input string name, input int idx);
        logic [14:0] act, e;
        act = {tstat, mcyc, ale, rd_, wr_, enb_c, enb_d, enbrr, enbwr, pcinc, halted};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s[%0d] scoreboard empty, got %b", name, idx, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL %s[%0d] got ts=%0d mc=%0d sb=%b expected ts=%0d mc=%0d sb=%b",
                         name, idx, act[14:12], act[11:9], act[8:0], e[14:12], e[11:9], e[8:0]);
            end
        end
    endtask

    task automatic run_table(input string name);
        foreach (tbl[i]) begin
            chk_i = tbl[i].chk;
            ready = tbl[i].rdy;
            exp_q.push_back({tbl[i].ts, tbl[i].mc, tbl[i].sb});
            @(posedge clk);
            @(negedge clk);
            compare(name, i);
        end
        tbl.delete();
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_  = 1'b1;
        chk_i = 13'd0;
        ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back({3'd0, 3'd0, IDL});
        compare(name, -1);
        rst_ = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // M1 only
        do_reset("basic_rst");
        add(13'h000, 1, 1, 0, ALE);
        add(13'h000, 1, 2, 0, RDP);
        add(13'h000, 1, 3, 0, RDC);
        add(13'h000, 1, 4, 0, T4W);
        add(13'h000, 1, 1, 0, ALE);
        run_table("basic");

        // M1 + two read cycles
        do_reset("reads_rst");
        add(13'h030, 1, 1, 0, ALE);
        add(13'h030, 1, 2, 0, RDP);
        add(13'h030, 1, 3, 0, RDC);
        add(13'h030, 1, 4, 0, T4R);
        add(13'h030, 1, 1, 1, ALE);
        add(13'h030, 1, 2, 1, RDP);
        add(13'h030, 1, 3, 1, RDD);
        add(13'h030, 1, 1, 2, ALE);
        add(13'h030, 1, 2, 2, RDP);
        add(13'h030, 1, 3, 2, RDD);
        add(13'h030, 1, 1, 0, ALW);
        add(13'h030, 1, 2, 0, RDP);
        run_table("reads");

        // M1 + one write cycle
        do_reset("write_rst");
        add(13'h110, 1, 1, 0, ALE);
        add(13'h110, 1, 2, 0, RDP);
        add(13'h110, 1, 3, 0, RDC);
        add(13'h110, 1, 4, 0, T4R);
        add(13'h110, 1, 1, 1, ALE);
        add(13'h110, 1, 2, 1, WRR);
        add(13'h110, 1, 3, 1, WRR);
        add(13'h110, 1, 1, 0, ALE);
        run_table("write");

        // wait states in M1
        do_reset("wait_rst");
        add(13'h000, 1, 1, 0, ALE);
        add(13'h000, 0, 2, 0, RDP);
        add(13'h000, 0, 7, 0, RDW);
        add(13'h000, 0, 7, 0, RDW);
        add(13'h000, 0, 7, 0, RDW);
        add(13'h000, 1, 3, 0, RDC);
        add(13'h000, 1, 4, 0, T4W);
        run_table("wait");

        // six-state M1, then halt after M2
        do_reset("halt_rst");
        add(13'h015, 1, 1, 0, ALE);
        add(13'h015, 1, 2, 0, RDP);
        add(13'h015, 1, 3, 0, RDC);
        add(13'h015, 1, 4, 0, T4R);
        add(13'h015, 1, 5, 0, IDL);
        add(13'h015, 1, 6, 0, IDL);
        add(13'h015, 1, 1, 1, ALE);
        add(13'h015, 1, 2, 1, RDP);
        add(13'h015, 1, 3, 1, RDD);
        for (int i = 0; i < 20; i++) add(13'h000, (i % 2 == 0), 0, 1, HLT);
        run_table("halt");

        // asynchronous reset during TW of M3
        do_reset("abort_rst");
        add(13'h030, 1, 1, 0, ALE);
        add(13'h030, 1, 2, 0, RDP);
        add(13'h030, 1, 3, 0, RDC);
        add(13'h030, 1, 4, 0, T4R);
        add(13'h030, 1, 1, 1, ALE);
        add(13'h030, 1, 2, 1, RDP);
        add(13'h030, 1, 3, 1, RDD);
        add(13'h030, 1, 1, 2, ALE);
        add(13'h030, 0, 2, 2, RDP);
        add(13'h030, 0, 7, 2, RDW);
        run_table("abort");
        #2;
        rst_ = 1'b1;
        #1;
        exp_q.push_back({3'd0, 3'd0, IDL});
        compare("abort_async", 0);
        @(posedge clk);
        @(negedge clk);
        exp_q.push_back({3'd0, 3'd0, IDL});
        compare("abort_hold", 0);
        rst_ = 1'b0;
        add(13'h000, 1, 1, 0, ALE);
        add(13'h000, 1, 2, 0, RDP);
        add(13'h000, 1, 3, 0, RDC);
        run_table("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
